// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction-fetch front end for the decode stage. It issues sequential
// word fetches to an instruction memory with a fixed 1-cycle read latency. It
// buffers the returned words in a DEPTH-entry FIFO and presents {IR, NPC} to
// decode through a valid/ready handshake. A redirect flushes the buffered
// entries and any in-flight fetch, then restarts fetch at the new PC.
//
// Optional build macro: FETCH_PERF_EN adds two saturating performance counters.
//
// Ports:
//   clk                : pipeline clock, rising-edge active
//   reset              : asynchronous active-low reset
//   imem_req/imem_addr : fetch request and word-aligned byte address
//   imem_rdata         : instruction word, valid 1 cycle after a request
//   redirect_valid/pc  : flush pulse and new fetch address (bits [1:0] ignored)
//   out_valid/ready    : head-entry handshake toward decode
//   out_ir/out_npc     : head instruction and its fetch address + 4
//   perf_stall_cycles  : (FETCH_PERF_EN) cycles with out_valid=1, out_ready=0
//   perf_flush_count   : (FETCH_PERF_EN) number of redirect pulses
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   req_addr_r;
  logic          inflight_r;
  logic          kill_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [31:0]   ir_mem_r  [DEPTH];
  logic [31:0]   npc_mem_r [DEPTH];

  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [AW+1:0] occupancy_s;
  logic [AW:0]   count_nxt_s;

  assign out_valid = (count_r != {(AW+1){1'b0}});
  assign out_ir    = ir_mem_r[rd_ptr_r];
  assign out_npc   = npc_mem_r[rd_ptr_r];
  assign imem_addr = pc_r;
  assign imem_req  = issue_s;

  // Handshake decode, credit check and next FIFO occupancy.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    issue_s     = 1'b0;
    occupancy_s = {(AW+2){1'b0}};
    count_nxt_s = count_r;
    if (redirect_valid) begin
      // A redirect clears the queue, so a coincident pop or push is moot.
      count_nxt_s = {(AW+1){1'b0}};
    end else begin
      pop_s  = out_valid & out_ready;
      push_s = inflight_r & ~kill_r;
      // An entry leaving this cycle already frees its slot for the next fetch.
      occupancy_s = {1'b0, count_r} + {{(AW+1){1'b0}}, inflight_r}
                    - {{(AW+1){1'b0}}, pop_s};
      issue_s     = reset & (occupancy_s < DEPTH_L);
      count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Fetch PC, outstanding-request tracking and FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      inflight_r <= 1'b0;
      kill_r     <= 1'b0;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
    end else if (redirect_valid) begin
      pc_r       <= {redirect_pc[31:2], 2'b00};
      inflight_r <= 1'b0;
      kill_r     <= inflight_r;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
    end else begin
      count_r    <= count_nxt_s;
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r       <= pc_r + 32'd4;
        req_addr_r <= pc_r;
        kill_r     <= 1'b0;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
    end
  end

  // FIFO storage; cleared on reset so the outputs read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_r[i]  <= 32'h0000_0000;
        npc_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      ir_mem_r[wr_ptr_r]  <= imem_rdata;
      npc_mem_r[wr_ptr_r] <= req_addr_r + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  assign perf_stall_cycles = stall_cnt_r;
  assign perf_flush_count  = flush_cnt_r;

  // Saturating counters for decode back-pressure and redirect pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'h0000_0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (redirect_valid && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_npc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_npc        (out_npc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  // Instruction memory: 1-cycle latency, data word = address >> 2.
  initial imem_rdata = 32'h0;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        chk;
    logic [31:0] ir;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    //                rst   rdy   rv    rpc           req   addr          vld   chk   ir            npc
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0});   // reset state
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 1'b1, 32'h0,        32'h4});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 1'b1, 32'h1,        32'h8});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 1'b1, 32'h2,        32'hC});
    // decode stalls: queue fills to DEPTH then fetch stops
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 1'b1, 32'h3,        32'h10});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 1'b1, 32'h3,        32'h10});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 1'b1, 32'h3,        32'h10});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 1'b1, 32'h3,        32'h10});
    // release: a pop in the same cycle frees credit
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 1'b1, 32'h3,        32'h10});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 1'b1, 32'h4,        32'h14});
    // redirect with 3 queued and a fetch in flight
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h24,       1'b1, 1'b1, 32'h5,        32'h18});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h44,       1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h48,       1'b1, 1'b1, 32'h10,       32'h44});
    // unaligned redirect target
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h23,       1'b0, 32'h4C,       1'b1, 1'b1, 32'h11,       32'h48});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b0, 1'b0, 32'h0,        32'h0});
    // PC wrap
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h24,       1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b1, 32'h3FFFFFFF, 32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 1'b1, 32'h0,        32'h4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 1'b1, 32'h1,        32'h8});
    // asynchronous reset with 2 queued, checked before any clock edge
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 1'b1, 32'h0,        32'h4});
    // back-to-back redirects: the last wins
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h100,      1'b0, 32'hC,        1'b1, 1'b1, 32'h1,        32'h8});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 32'h100,      1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b0, 1'b0, 32'h0,        32'h0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 1'b1, 32'h80,       32'h204});

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      check32($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      check32($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
      check32($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].vld});
      if (tbl[i].chk) begin
        check32($sformatf("v%0d out_ir", i), out_ir, tbl[i].ir);
        check32($sformatf("v%0d out_npc", i), out_npc, tbl[i].npc);
      end
    end

`ifdef FETCH_PERF_EN
    // 5 stalled cycles followed by 2 redirect pulses
    apply(1'b0, 1'b0, 1'b0, 32'h0);
    check32("perf stall reset", perf_stall_cycles, 32'd0);
    check32("perf flush reset", {16'h0, perf_flush_count}, 32'd0);
    for (int k = 0; k < 7; k++) apply(1'b1, 1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b1, 1'b1, 32'h80);
    apply(1'b1, 1'b1, 1'b1, 32'h90);
    apply(1'b1, 1'b1, 1'b0, 32'h0);
    check32("perf stall count", perf_stall_cycles, 32'd5);
    check32("perf flush count", {16'h0, perf_flush_count}, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
